// File: rtl/nand_cpu_pkg.sv
// Shared definitions for the nand_cpu system: loader states and framing constants.
// PC_SIZE sets the instruction-memory address width. A fallback is provided
// for builds that do not define it.
`ifndef PC_SIZE
`define PC_SIZE 8
`endif

package nand_cpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } loader_state_e;

  localparam logic [7:0]  LOADER_SYNC_BYTE = 8'hA5;
  localparam int unsigned LOADER_LEN_W     = 16;

endpackage

// File: rtl/loader_frame_fsm.sv
// Frame parser for imem_loader: holds the state register, the length latch and
// the running XOR checksum, and drives the registered handshake/status outputs.
// Build option IMEM_LOADER_CSUM_EN: when defined, a trailing checksum byte is
// expected and checked; otherwise the frame ends after the last data byte.
module loader_frame_fsm
  import nand_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = `PC_SIZE,
  parameter int unsigned DEPTH     = 2**ADDR_W,
  parameter logic [7:0]  SYNC_BYTE = LOADER_SYNC_BYTE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  input  logic            restart,
  input  logic [ADDR_W:0] words_loaded,
  output logic            in_ready,
  output logic            cpu_hold,
  output logic            load_done,
  output logic            load_err,
  output logic            data_accept_c,
  output logic            count_clear_c
);

  loader_state_e state, state_next;
  logic [LOADER_LEN_W-1:0] len, len_next;
  logic accept_c;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] csum, csum_next;
`endif

  assign accept_c = in_valid & in_ready;

  // Next-state, length latch and checksum update.
  always_comb begin
    state_next    = state;
    len_next      = len;
    data_accept_c = 1'b0;
    count_clear_c = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
    csum_next     = csum;
`endif
    case (state)
      IDLE: begin
        if (accept_c && (in_data == SYNC_BYTE)) state_next = LEN_LO;
      end
      LEN_LO: begin
        if (accept_c) begin
          len_next[7:0] = in_data;
          state_next    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept_c) begin
          len_next[15:8] = in_data;
          count_clear_c  = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_next      = 8'h00;
`endif
          if (32'(len_next) > DEPTH) begin
            state_next = ERROR;
          end else if (len_next == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (accept_c) begin
          data_accept_c = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_next     = csum ^ in_data;
`endif
          // Last byte when the post-increment count reaches len.
          if ((32'(words_loaded) + 32'd1) == 32'(len)) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (accept_c) state_next = (in_data == csum) ? DONE : ERROR;
      end
`endif
      DONE, ERROR: begin
        if (restart) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; status outputs are registered from the next state so they
  // always agree with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      in_ready  <= 1'b0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      state     <= state_next;
      len       <= len_next;
      in_ready  <= (state_next != DONE) && (state_next != ERROR);
      cpu_hold  <= (state_next != DONE);
      load_done <= (state_next == DONE);
      load_err  <= (state_next == ERROR);
`ifdef IMEM_LOADER_CSUM_EN
      csum      <= csum_next;
`endif
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: writes a framed program into instruction memory
// from address 0 and holds the CPU in reset until a frame loads cleanly.
// Build option IMEM_LOADER_CSUM_EN enables the trailing XOR checksum byte.
// n_rst is an asynchronous, active-high reset despite its name.
module imem_loader
  import nand_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = `PC_SIZE,
  parameter int unsigned DEPTH     = 2**ADDR_W,
  parameter logic [7:0]  SYNC_BYTE = LOADER_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic data_accept_c;
  logic count_clear_c;

  loader_frame_fsm #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .SYNC_BYTE (SYNC_BYTE)
  ) u_frame_fsm (
    .clk           (clk),
    .rst           (n_rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .restart       (restart),
    .words_loaded  (words_loaded),
    .in_ready      (in_ready),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_err      (load_err),
    .data_accept_c (data_accept_c),
    .count_clear_c (count_clear_c)
  );

  // Write-port stage (one cycle after acceptance) and per-frame byte counter.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= 8'h00;
      words_loaded <= '0;
    end else begin
      imem_we <= data_accept_c;
      if (data_accept_c) begin
        imem_waddr <= words_loaded[ADDR_W-1:0];
        imem_wdata <= in_data;
      end
      if (count_clear_c) begin
        words_loaded <= '0;
      end else if (data_accept_c) begin
        words_loaded <= words_loaded + CNT_W'(1);
      end
    end
  end

endmodule
